// File: rtl/axi_mem_preloader.sv
`timescale 1ns/1ps
// axi_mem_preloader: AXI4 write master that streams a word sequence into
// memory as INCR bursts, split at MAX_BURST_LEN beats and at 4 KiB pages,
// with a single burst outstanding at a time.
module axi_mem_preloader #(
  parameter int unsigned            AXI_ID_WIDTH      = 5,
  parameter int unsigned            AXI_ADDRESS_WIDTH = 64,
  parameter int unsigned            AXI_DATA_WIDTH    = 64,
  parameter int unsigned            AXI_USER_WIDTH    = 1,
  parameter int unsigned            MAX_BURST_LEN     = 16,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID           = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // job control
  input  logic                          start_i,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  base_addr_i,
  input  logic [31:0]                   num_words_i,
  // word stream
  input  logic                          data_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]     data_i,
  output logic                          data_ready_o,
  // status
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o,
  // AXI AW
  output logic [AXI_ID_WIDTH-1:0]       axi_aw_id_o,
  output logic [AXI_ADDRESS_WIDTH-1:0]  axi_aw_addr_o,
  output logic [7:0]                    axi_aw_len_o,
  output logic [2:0]                    axi_aw_size_o,
  output logic [1:0]                    axi_aw_burst_o,
  output logic                          axi_aw_lock_o,
  output logic [3:0]                    axi_aw_cache_o,
  output logic [2:0]                    axi_aw_prot_o,
  output logic [3:0]                    axi_aw_qos_o,
  output logic [3:0]                    axi_aw_region_o,
  output logic [AXI_USER_WIDTH-1:0]     axi_aw_user_o,
  output logic                          axi_aw_valid_o,
  input  logic                          axi_aw_ready_i,
  // AXI W
  output logic [AXI_DATA_WIDTH-1:0]     axi_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   axi_w_strb_o,
  output logic                          axi_w_last_o,
  output logic [AXI_USER_WIDTH-1:0]     axi_w_user_o,
  output logic                          axi_w_valid_o,
  input  logic                          axi_w_ready_i,
  // AXI B
  input  logic [AXI_ID_WIDTH-1:0]       axi_b_id_i,
  input  logic [1:0]                    axi_b_resp_i,
  input  logic [AXI_USER_WIDTH-1:0]     axi_b_user_i,
  input  logic                          axi_b_valid_i,
  output logic                          axi_b_ready_o,
  // AXI AR (unused, held idle)
  output logic [AXI_ID_WIDTH-1:0]       axi_ar_id_o,
  output logic [AXI_ADDRESS_WIDTH-1:0]  axi_ar_addr_o,
  output logic [7:0]                    axi_ar_len_o,
  output logic [2:0]                    axi_ar_size_o,
  output logic [1:0]                    axi_ar_burst_o,
  output logic                          axi_ar_lock_o,
  output logic [3:0]                    axi_ar_cache_o,
  output logic [2:0]                    axi_ar_prot_o,
  output logic [3:0]                    axi_ar_qos_o,
  output logic [3:0]                    axi_ar_region_o,
  output logic [AXI_USER_WIDTH-1:0]     axi_ar_user_o,
  output logic                          axi_ar_valid_o,
  input  logic                          axi_ar_ready_i,
  // AXI R (unused, always accepted)
  input  logic [AXI_ID_WIDTH-1:0]       axi_r_id_i,
  input  logic [AXI_DATA_WIDTH-1:0]     axi_r_data_i,
  input  logic [1:0]                    axi_r_resp_i,
  input  logic                          axi_r_last_i,
  input  logic [AXI_USER_WIDTH-1:0]     axi_r_user_i,
  input  logic                          axi_r_valid_i,
  output logic                          axi_r_ready_o
);

  localparam int unsigned NB      = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W   = $clog2(NB);
  localparam int unsigned AW      = AXI_ADDRESS_WIDTH;
  localparam int unsigned LEN_W   = 9;   // holds 1..256 beats
  localparam int unsigned PAGE_W  = 13;  // holds 4096
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [31:0]        rem_q, rem_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]   blen_q, blen_d;
  logic               error_q, error_d;
  logic               busy_q, done_q;

  logic [PAGE_W-1:0]  page_beats_c;
  logic [31:0]        beats_c;
  logic [LEN_W-1:0]   burst_beats_c;
  logic [7:0]         aw_len_c;
  logic               aw_valid_c, w_valid_c, w_last_c, b_ready_c, data_ready_c;
  logic               busy_d, done_d;

  // Beats of the next burst: bounded by remaining words, max length and page end.
  always_comb begin
    page_beats_c = PAGE_W'(PAGE_W'(4096) - {1'b0, addr_q[11:0]}) >> OFF_W;
    beats_c      = rem_q;
    if (beats_c > 32'(MAX_BURST_LEN)) begin
      beats_c = 32'(MAX_BURST_LEN);
    end
    if (beats_c > 32'(page_beats_c)) begin
      beats_c = 32'(page_beats_c);
    end
    burst_beats_c = LEN_W'(beats_c);
    aw_len_c      = 8'(burst_beats_c - LEN_W'(1));
  end

  // Next-state, datapath updates and channel handshake controls.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    blen_d       = blen_q;
    error_d      = error_q;
    aw_valid_c   = 1'b0;
    w_valid_c    = 1'b0;
    w_last_c     = 1'b0;
    b_ready_c    = 1'b0;
    data_ready_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i & ~AW'(NB - 1);
          rem_d   = num_words_i;
          error_d = 1'b0;
          state_d = (num_words_i == 32'd0) ? ST_DONE : ST_AW;
        end
      end
      ST_AW: begin
        aw_valid_c = 1'b1;
        if (axi_aw_ready_i) begin
          cnt_d   = aw_len_c;
          blen_d  = burst_beats_c;
          state_d = ST_W;
        end
      end
      ST_W: begin
        w_valid_c    = data_valid_i;
        w_last_c     = (cnt_q == 8'd0);
        data_ready_c = axi_w_ready_i;
        if (data_valid_i && axi_w_ready_i) begin
          if (cnt_q == 8'd0) begin
            state_d = ST_B;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_B: begin
        b_ready_c = 1'b1;
        if (axi_b_valid_i) begin
          if (axi_b_resp_i != RESP_OKAY) begin
            error_d = 1'b1;
          end
          addr_d  = addr_q + (AW'(blen_q) << OFF_W);
          rem_d   = rem_q - 32'(blen_q);
          state_d = (rem_q == 32'(blen_q)) ? ST_DONE : ST_AW;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags follow the state being entered so they line up with it.
  always_comb begin
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_AW) || (state_d == ST_W) || (state_d == ST_B);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      blen_q  <= '0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      blen_q  <= blen_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign data_ready_o = data_ready_c;

  // AW fields come from registers that are frozen while waiting for aw_ready.
  assign axi_aw_id_o     = AXI_ID;
  assign axi_aw_addr_o   = addr_q;
  assign axi_aw_len_o    = aw_len_c;
  assign axi_aw_size_o   = 3'(OFF_W);
  assign axi_aw_burst_o  = BURST_INCR;
  assign axi_aw_lock_o   = 1'b0;
  assign axi_aw_cache_o  = '0;
  assign axi_aw_prot_o   = '0;
  assign axi_aw_qos_o    = '0;
  assign axi_aw_region_o = '0;
  assign axi_aw_user_o   = '0;
  assign axi_aw_valid_o  = aw_valid_c;

  assign axi_w_data_o    = data_i;
  assign axi_w_strb_o    = '1;
  assign axi_w_last_o    = w_last_c;
  assign axi_w_user_o    = '0;
  assign axi_w_valid_o   = w_valid_c;

  assign axi_b_ready_o   = b_ready_c;

  assign axi_ar_id_o     = '0;
  assign axi_ar_addr_o   = '0;
  assign axi_ar_len_o    = '0;
  assign axi_ar_size_o   = '0;
  assign axi_ar_burst_o  = '0;
  assign axi_ar_lock_o   = 1'b0;
  assign axi_ar_cache_o  = '0;
  assign axi_ar_prot_o   = '0;
  assign axi_ar_qos_o    = '0;
  assign axi_ar_region_o = '0;
  assign axi_ar_user_o   = '0;
  assign axi_ar_valid_o  = 1'b0;
  assign axi_r_ready_o   = 1'b1;

  // Inputs of the idle read channel and the B sideband are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{axi_b_id_i, axi_b_user_i, axi_ar_ready_i, axi_r_id_i,
                           axi_r_data_i, axi_r_resp_i, axi_r_last_i, axi_r_user_i,
                           axi_r_valid_i};

endmodule
